// File: rtl/lcd_pkg.sv
// Shared types and 12 MHz default timing for the character-LCD path
// (lcd_controller and lcd_write_sequencer).
package lcd_pkg;

    typedef enum logic [2:0] {
        PWR_RST,
        PWR_WAIT,
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        WAIT
    } lcd_wr_state_e;

    localparam int LCD_RESET_CYCLES      = 120;
    localparam int LCD_POWERUP_CYCLES    = 480000;
    localparam int LCD_SETUP_CYCLES      = 2;
    localparam int LCD_ENABLE_CYCLES     = 6;
    localparam int LCD_HOLD_CYCLES       = 2;
    localparam int LCD_SHORT_WAIT_CYCLES = 444;
    localparam int LCD_LONG_WAIT_CYCLES  = 18240;

    function automatic int lcd_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_cycle_timer.sv
// Restartable cycle timer: load_i clears it, done_o flags the last cycle
// of a len_i-cycle interval so the FSM can change state on that edge.
module lcd_cycle_timer #(
    parameter int CW = 8
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    input  logic          load_i,
    input  logic [CW-1:0] len_i,
    output logic          done_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = load_i ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) cnt_q <= '0;
        else            cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == len_i - CW'(1));

endmodule

// File: rtl/lcd_write_sequencer.sv
// Pin-level write timing for a character LCD, including power-on reset.
// Optional register-select passthrough is built when LCD_RS_EN is defined.
module lcd_write_sequencer
    import lcd_pkg::*;
#(
    parameter int RESET_CYCLES      = LCD_RESET_CYCLES,
    parameter int POWERUP_CYCLES    = LCD_POWERUP_CYCLES,
    parameter int SETUP_CYCLES      = LCD_SETUP_CYCLES,
    parameter int ENABLE_CYCLES     = LCD_ENABLE_CYCLES,
    parameter int HOLD_CYCLES       = LCD_HOLD_CYCLES,
    parameter int SHORT_WAIT_CYCLES = LCD_SHORT_WAIT_CYCLES,
    parameter int LONG_WAIT_CYCLES  = LCD_LONG_WAIT_CYCLES
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       valid_i,
    input  logic [7:0] data_i,
    input  logic       long_i,
`ifdef LCD_RS_EN
    input  logic       rs_i,
    output logic       lcd_rs_o,
`endif
    output logic       ready_o,
    output logic [7:0] lcd_data_o,
    output logic       lcd_reset_o,
    output logic       lcd_enable_o
);

    localparam int MAX_CYC = lcd_max(lcd_max(lcd_max(RESET_CYCLES, POWERUP_CYCLES),
                                             lcd_max(SETUP_CYCLES, ENABLE_CYCLES)),
                                     lcd_max(HOLD_CYCLES,
                                             lcd_max(SHORT_WAIT_CYCLES, LONG_WAIT_CYCLES)));
    localparam int CW = $clog2(MAX_CYC + 1);

    lcd_wr_state_e state_q, state_d;
    logic [7:0]    data_q, data_d;
    logic          long_q, long_d;
    logic          ready_q, ready_d;
    logic          en_q, en_d;
    logic          rst_q, rst_d;
    logic [CW-1:0] len;
    logic          done;
    logic          load;
`ifdef LCD_RS_EN
    logic          rs_q, rs_d;
`endif

    always_comb begin
        len = CW'(1);
        case (state_q)
            PWR_RST:  len = CW'(RESET_CYCLES);
            PWR_WAIT: len = CW'(POWERUP_CYCLES);
            SETUP:    len = CW'(SETUP_CYCLES);
            PULSE:    len = CW'(ENABLE_CYCLES);
            HOLD:     len = CW'(HOLD_CYCLES);
            WAIT:     len = long_q ? CW'(LONG_WAIT_CYCLES) : CW'(SHORT_WAIT_CYCLES);
            default:  len = CW'(1);
        endcase
    end

    // Every output is decided here one cycle ahead and registered below,
    // so enable can never glitch from state decode.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        long_d  = long_q;
        ready_d = ready_q;
        en_d    = en_q;
        rst_d   = rst_q;
`ifdef LCD_RS_EN
        rs_d    = rs_q;
`endif
        case (state_q)
            PWR_RST: if (done) begin
                state_d = PWR_WAIT;
                rst_d   = 1'b0;
            end
            PWR_WAIT: if (done) begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            IDLE: if (valid_i && ready_q) begin
                state_d = SETUP;
                data_d  = data_i;
                long_d  = long_i;
                ready_d = 1'b0;
`ifdef LCD_RS_EN
                rs_d    = rs_i;
`endif
            end
            SETUP: if (done) begin
                state_d = PULSE;
                en_d    = 1'b1;
            end
            PULSE: if (done) begin
                state_d = HOLD;
                en_d    = 1'b0;
            end
            HOLD: if (done) state_d = WAIT;
            WAIT: if (done) begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: state_d = PWR_RST;
        endcase
    end

    // Timer restarts on every state change and is parked while idle.
    assign load = (state_d != state_q) || (state_q == IDLE);

    lcd_cycle_timer #(.CW(CW)) u_timer (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .load_i    (load),
        .len_i     (len),
        .done_o    (done)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= PWR_RST;
            data_q  <= 8'h00;
            long_q  <= 1'b0;
            ready_q <= 1'b0;
            en_q    <= 1'b0;
            rst_q   <= 1'b1;
`ifdef LCD_RS_EN
            rs_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            long_q  <= long_d;
            ready_q <= ready_d;
            en_q    <= en_d;
            rst_q   <= rst_d;
`ifdef LCD_RS_EN
            rs_q    <= rs_d;
`endif
        end
    end

    assign ready_o      = ready_q;
    assign lcd_data_o   = data_q;
    assign lcd_enable_o = en_q;
    assign lcd_reset_o  = rst_q;
`ifdef LCD_RS_EN
    assign lcd_rs_o     = rs_q;
`endif

endmodule
